// File: rtl/iiitb_sqd_pkg.sv
// Shared types and constants for the iiitb_sqd frame controller.
package iiitb_sqd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StReport
  } state_e;

  // Pattern loaded at reset unless the top overrides RESET_PAT.
  localparam logic [3:0] DefaultPat = 4'b1010;

endpackage

// File: rtl/iiitb_sqd_ctrl_if.sv
// Frame-in / result-out valid/ready handshakes of the iiitb_sqd controller.
interface iiitb_sqd_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [CNT_W-1:0]  out_count;
  logic              out_ready;

  // Producer/consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_count
  );

  // Controller side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_count
  );

endinterface

// File: rtl/iiitb_sqd_match.sv
// Bit-serial pattern matcher: PAT_W history, consumed-bit count, comparator.
// Macro IIITB_SQD_NONOVL_EN selects non-overlapping detection.
module iiitb_sqd_match #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             bit_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit,
  output logic             pulse
);

  localparam int unsigned SeenW = $clog2(PAT_W + 1);

  logic [PAT_W-1:0] hist_q, hist_d, hist_shift;
  logic [SeenW-1:0] seen_q, seen_d, seen_inc;
  logic             pulse_q;

  // Compare the history including the current bit; the seen count saturates at PAT_W.
  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], bit_in};
    seen_inc   = (seen_q == SeenW'(PAT_W)) ? seen_q : seen_q + SeenW'(1);
    hit        = bit_en && (hist_shift == pattern) && (seen_inc == SeenW'(PAT_W));
    hist_d     = hist_q;
    seen_d     = seen_q;
    if (clr) begin
      hist_d = '0;
      seen_d = '0;
    end else if (bit_en) begin
      hist_d = hist_shift;
      seen_d = seen_inc;
`ifdef IIITB_SQD_NONOVL_EN
      // Next hit needs PAT_W fresh bits.
      if (hit) begin
        hist_d = '0;
        seen_d = '0;
      end
`endif
    end
  end

  // History, seen count and the one-cycle-late match pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q  <= '0;
      seen_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      seen_q  <= seen_d;
      pulse_q <= hit;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/iiitb_sqd_ctrl.sv
// Frame controller: accepts a word, shifts it MSB-first through the matcher,
// counts hits (saturating) and returns the count over a valid/ready handshake.
// Macro IIITB_SQD_NONOVL_EN (in iiitb_sqd_match) selects non-overlapping detection.
module iiitb_sqd_ctrl
  import iiitb_sqd_pkg::*;
#(
  parameter int unsigned     DATA_W    = 8,
  parameter int unsigned     PAT_W     = 4,
  parameter int unsigned     CNT_W     = 4,
  parameter logic [PAT_W-1:0] RESET_PAT = PAT_W'(DefaultPat)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  iiitb_sqd_ctrl_if.slave  bus,
  output logic             busy,
  output logic             match_pulse
);

  localparam int unsigned BitW = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e            state_q, state_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]   bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]  hitcnt_q, hitcnt_d;
  logic              clr, bit_en, hit;

  // Next-state, datapath updates and matcher controls.
  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    hitcnt_d = hitcnt_q;
    clr      = 1'b0;
    bit_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Pattern written alongside a frame load applies to that frame.
        if (cfg_we) pat_d = cfg_pattern;
        if (bus.in_valid) begin
          shreg_d  = bus.in_data;
          bitcnt_d = '0;
          hitcnt_d = '0;
          clr      = 1'b1;
          state_d  = StShift;
        end
      end
      StShift: begin
        bit_en   = 1'b1;
        shreg_d  = {shreg_q[DATA_W-2:0], 1'b0};
        bitcnt_d = bitcnt_q + BitW'(1);
        if (hit && (hitcnt_q != CntMax)) hitcnt_d = hitcnt_q + CNT_W'(1);
        if (bitcnt_q == BitW'(DATA_W - 1)) state_d = StReport;
      end
      StReport: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      pat_q    <= RESET_PAT;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      hitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      hitcnt_q <= hitcnt_d;
    end
  end

  iiitb_sqd_match #(
    .PAT_W (PAT_W)
  ) u_match (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .bit_en  (bit_en),
    .bit_in  (shreg_q[DATA_W-1]),
    .pattern (pat_q),
    .hit     (hit),
    .pulse   (match_pulse)
  );

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StReport);
  assign bus.out_count = hitcnt_q;
  assign busy          = (state_q != StIdle);

endmodule
